// File: rtl/fxp_divider_ovf.sv
// Iterative unsigned fixed-point divider q = (a << FRAC) / b, one bit per clock,
// with overflow / divide-by-zero saturation and optional early abort.
module fxp_divider_ovf #(
  parameter  int WIDTH       = 10,
  parameter  int FRAC        = 4,
  parameter  int EARLY_ABORT = 1,
  localparam int ITER        = WIDTH + FRAC,
  localparam int CW          = $clog2(ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             ovf,
  output logic             dbz,
  output logic [CW-1:0]    iter_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST   = CW'(ITER - 1);
  localparam logic [CW-1:0] FRAC_C = CW'(FRAC);

  state_t state, next;

  logic [WIDTH-1:0] bq;
  logic [ITER-1:0]  num;
  logic [WIDTH:0]   pr;
  logic [WIDTH-2:0] qs;

  logic             accept;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH:0]   new_pr;
  logic [WIDTH-1:0] qn;
  logic             ovf_now;
  logic             last;

  always_comb begin
    accept  = start && (state != S_CALC);
    rem_sh  = {pr[WIDTH-1:0], num[ITER-1]};
    // pr < b always, so the shifted remainder fits WIDTH+1 bits
    diff    = {pr, num[ITER-1]} - {2'b00, bq};
    qbit    = ~diff[WIDTH+1];
    new_pr  = qbit ? diff[WIDTH:0] : rem_sh;
    qn      = {qs, qbit};
    ovf_now = qbit && (iter_cnt < FRAC_C);
    last    = (iter_cnt == LAST) ||
              (ovf_now && (EARLY_ABORT != 0));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next = (b == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last) next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) next = (b == '0) ? S_DONE : S_CALC;
        else       next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bq       <= '0;
      num      <= '0;
      pr       <= '0;
      qs       <= '0;
      q        <= '0;
      r        <= '0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
      iter_cnt <= '0;
    end else if (accept) begin
      bq       <= b;
      num      <= ITER'(a) << FRAC;
      pr       <= '0;
      qs       <= '0;
      q        <= (b == '0) ? '1 : '0;
      r        <= '0;
      ovf      <= 1'b0;
      dbz      <= (b == '0);
      iter_cnt <= '0;
    end else if (state == S_CALC) begin
      num      <= num << 1;
      pr       <= new_pr;
      qs       <= qn[WIDTH-2:0];
      iter_cnt <= iter_cnt + CW'(1);
      if (ovf_now) ovf <= 1'b1;
      if (last) begin
        // any overflow saturates, whether or not we aborted
        if (ovf || ovf_now) begin
          q <= '1;
          r <= '0;
        end else begin
          q <= qn;
          r <= new_pr[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fxp_divider_ovf.sv
// Directed bench for fxp_divider_ovf: defaults, EARLY_ABORT=0,
// and a WIDTH=16/FRAC=8 instance checked against a reference model.
module tb_fxp_divider_ovf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [9:0] a, b;

  logic       busy0, done0, ovf0, dbz0;
  logic [9:0] q0, r0;
  logic [3:0] it0;
  logic       busy1, done1, ovf1, dbz1;
  logic [9:0] q1, r1;
  logic [3:0] it1;

  logic        start2;
  logic [15:0] a2, b2;
  logic        busy2, done2, ovf2, dbz2;
  logic [15:0] q2, r2;
  logic [4:0]  it2;

  fxp_divider_ovf u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .q(q0), .r(r0),
    .ovf(ovf0), .dbz(dbz0), .iter_cnt(it0)
  );

  fxp_divider_ovf #(.EARLY_ABORT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .q(q1), .r(r1),
    .ovf(ovf1), .dbz(dbz1), .iter_cnt(it1)
  );

  fxp_divider_ovf #(.WIDTH(16), .FRAC(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .q(q2), .r(r2),
    .ovf(ovf2), .dbz(dbz2), .iter_cnt(it2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         lat0, lat1, lat2;
  logic       saw_busy;
  logic [9:0] cq0, cr0, cq1, cr1;
  logic       cov0, cdz0, cov1, cdz1;
  logic [3:0] cit0, cit1;
  logic [15:0] cq2, cr2;
  logic        cov2, cdz2;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go(input logic [9:0] ta, input logic [9:0] tb_);
    a = ta; b = tb_; start = 1'b1;
    lat0 = 0; lat1 = 0; saw_busy = 1'b0;
    for (int n = 1; n <= 40 && (lat0 == 0 || lat1 == 0); n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy0) saw_busy = 1'b1;
      if (done0 && lat0 == 0) begin
        lat0 = n; cq0 = q0; cr0 = r0; cov0 = ovf0; cdz0 = dbz0; cit0 = it0;
      end
      if (done1 && lat1 == 0) begin
        lat1 = n; cq1 = q1; cr1 = r1; cov1 = ovf1; cdz1 = dbz1; cit1 = it1;
      end
    end
  endtask

  task automatic go2(input logic [15:0] ta, input logic [15:0] tb_);
    a2 = ta; b2 = tb_; start2 = 1'b1; lat2 = 0;
    for (int n = 1; n <= 40 && lat2 == 0; n++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (done2) begin
        lat2 = n; cq2 = q2; cr2 = r2; cov2 = ovf2; cdz2 = dbz2;
      end
    end
  endtask

  task automatic sweep(input logic [15:0] ta, input logic [15:0] tb_);
    logic [63:0] num, qf;
    logic [15:0] eq, er;
    logic        eo, ed;
    int          el, p;
    num = {40'd0, ta, 8'd0};
    eo = 1'b0; ed = 1'b0; er = '0; eq = '1; el = 25; p = -1;
    if (tb_ == 16'd0) begin
      ed = 1'b1; el = 1;
    end else begin
      qf = num / {48'd0, tb_};
      if (qf >= 64'd65536) begin
        eo = 1'b1;
        for (int i = 23; i >= 16; i--)
          if (qf[i] && p < 0) p = i;
        el = (24 - p) + 1;
      end else begin
        eq = qf[15:0];
        er = 16'(num % {48'd0, tb_});
      end
    end
    go2(ta, tb_);
    check("w16_lat", 64'(lat2), 64'(el));
    check("w16_q",   64'(cq2),  64'(eq));
    check("w16_r",   64'(cr2),  64'(er));
    check("w16_ovf", 64'(cov2), 64'(eo));
    check("w16_dbz", 64'(cdz2), 64'(ed));
  endtask

  initial begin
    int dpulses;
    logic [15:0] ra, rb;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_q",    64'(q0),    64'd0);
    check("rst_it",   64'(it0),   64'd0);
    check("rst_w16",  64'({busy2, done2, q2}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    go(10'd48, 10'd32);
    check("t1_lat", 64'(lat0), 64'd15);
    check("t1_q",   64'(cq0),  64'd24);
    check("t1_r",   64'(cr0),  64'd0);
    check("t1_flg", 64'({cov0, cdz0}), 64'd0);
    check("t1_it",  64'(cit0), 64'd14);

    go(10'd1023, 10'd1);
    check("ab_lat",  64'(lat0), 64'd2);
    check("ab_ovf",  64'(cov0), 64'd1);
    check("ab_q",    64'(cq0),  64'd1023);
    check("ab_r",    64'(cr0),  64'd0);
    check("ab_it",   64'(cit0), 64'd1);
    check("nab_lat", 64'(lat1), 64'd15);
    check("nab_ovf", 64'(cov1), 64'd1);
    check("nab_q",   64'(cq1),  64'd1023);
    check("nab_r",   64'(cr1),  64'd0);
    check("nab_it",  64'(cit1), 64'd14);

    go(10'd5, 10'd0);
    check("dz_lat",  64'(lat0), 64'd1);
    check("dz_dbz",  64'(cdz0), 64'd1);
    check("dz_q",    64'(cq0),  64'd1023);
    check("dz_ovf",  64'(cov0), 64'd0);
    check("dz_busy", 64'(saw_busy), 64'd0);

    go(10'd100, 10'd7);
    check("d7_q",   64'(cq0),  64'd228);
    check("d7_r",   64'(cr0),  64'd4);
    check("d7_ovf", 64'(cov0), 64'd0);
    go(10'd16, 10'd16);
    check("b2b_lat", 64'(lat0), 64'd15);
    check("b2b_q",   64'(cq0),  64'd16);
    check("b2b_r",   64'(cr0),  64'd0);

    repeat (2) @(posedge clk);
    #1;
    a = 10'd200; b = 10'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 10'd1; b = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat0 = 0;
    for (int n = 1; n <= 30 && lat0 == 0; n++) begin
      if (done0) begin
        lat0 = n; cq0 = q0; cr0 = r0; cov0 = ovf0;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("ign_seen", 64'(lat0 != 0), 64'd1);
    check("ign_q",    64'(cq0),  64'd355);
    check("ign_r",    64'(cr0),  64'd5);
    check("ign_ovf",  64'(cov0), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    a = 10'd48; b = 10'd32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy0), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mr_out", 64'({busy0, done0, q0, r0, ovf0, dbz0, it0}), 64'd0);
    rst = 1'b1;
    dpulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 || busy0) dpulses++;
    end
    check("mr_quiet", 64'(dpulses), 64'd0);

    sweep(16'd65535, 16'd1);
    sweep(16'd300, 16'd0);
    sweep(16'd1, 16'd65535);
    sweep(16'd1000, 16'd3);
    for (int k = 0; k < 10; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      sweep(ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fxp_divider_ovf.md
Name: fxp_divider_ovf

Overview:
- Parametrised iterative unsigned fixed-point divider with a built-in iteration counter and overflow detector.
- Computes q = (a << FRAC) / b using restoring division, one quotient bit per clock.
- Flags quotient overflow and divide-by-zero, saturates the result in both cases, and optionally aborts early on overflow.
- Successor to the fixed 14-iteration counter plus overflow-detector pair in the divider datapath.

Parameters:
- WIDTH, 10: operand, quotient and remainder width in bits (unsigned fixed point).
- FRAC, 4: number of fractional bits in a, b and q.
- EARLY_ABORT, 1: 1 terminates the calculation the cycle after overflow is detected; 0 always runs all iterations.
- Derived, not overridable: ITER = WIDTH+FRAC; CW = $clog2(ITER+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a division; sampled only when busy=0.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse when the result is valid.
- q  out  WIDTH  quotient; held until the next accepted start.
- r  out  WIDTH  integer remainder of (a<<FRAC)/b; held with q.
- ovf  out  1  quotient overflow; held with q.
- dbz  out  1  divide-by-zero; held with q.
- iter_cnt  out  CW  number of completed iterations.

Behaviour:
- Reset: when rst=0 at a clock edge, state=IDLE and busy, done, q, r, ovf, dbz, iter_cnt all become 0. Reset overrides everything, including mid-CALC; a partial result is discarded and no done is issued.
- States:
  - IDLE: wait for start.
  - CALC: one quotient bit per cycle.
  - DONE: single cycle, done=1.
- Start acceptance: start=1 is accepted only in IDLE or DONE; it is ignored in CALC.
  - On acceptance, latch a and b, clear ovf, dbz, iter_cnt, q and r, and set the partial remainder to 0.
- Divide by zero: if b=0 at acceptance, go directly to DONE (done one cycle after the start edge) with q = all ones, r=0, dbz=1, ovf=0.
- Otherwise go to CALC with busy=1. Each cycle:
  - Shift the next numerator bit (MSB first, ITER-bit numerator a<<FRAC) into the partial remainder, which is WIDTH+1 bits wide.
  - Subtract b; if the result is non-negative, keep it and the quotient bit is 1, else the quotient bit is 0.
  - Increment iter_cnt.
- Overflow rule: quotient bits of weight 2^(ITER-1) down to 2^WIDTH, i.e. the first FRAC iterations, must be 0.
  - Any 1 in those iterations sets ovf on that same edge.
  - EARLY_ABORT=1: the next state is DONE and iter_cnt freezes.
  - EARLY_ABORT=0: run all ITER iterations.
  - In both modes the final result is q = all ones, r=0.
- Normal completion: after ITER iterations (iter_cnt=ITER), go to DONE. q holds the low WIDTH quotient bits, r the final partial remainder (always < b).
- Latency:
  - Start sampled at edge E0; busy=1 during cycles E0..E(ITER).
  - Final iteration on edge E(ITER); done=1 for the cycle after E(ITER).
  - Total ITER+1 edges from start to done (15 at defaults).
- DONE always returns to IDLE on the next edge, unless start=1 in DONE, in which case a new operation is accepted (back-to-back). q, r, ovf and dbz remain valid until that acceptance edge.
- Quotient semantics: truncation, no rounding. Outputs are valid only when done=1 or afterwards, in IDLE.

Test Plan:
- a=48 (3.0), b=32 (2.0), defaults -> done exactly 15 edges after start; q=24 (1.5), r=0, ovf=0, dbz=0, iter_cnt=14.
- a=1023, b=1, EARLY_ABORT=1 -> ovf=1 at first iteration, done 2 edges after start, q=1023, r=0, iter_cnt=1. Same operands with EARLY_ABORT=0 -> done after 15 edges, ovf=1, q=1023, iter_cnt=14.
- a=5, b=0 -> done 1 edge after start; dbz=1, q=1023, ovf=0, busy never asserted.
- a=100, b=7 -> q=228, r=4 ((100<<4)=1600=7*228+4), ovf=0. Then assert start in the DONE cycle with a=16, b=16 -> accepted back-to-back, q=16.
- Pulse start during CALC with different operands -> ignored, first result unchanged. Drive rst=0 at iteration 7 of a new operation -> next edge all outputs 0, state IDLE, no done pulse.
- Parameter sweep WIDTH=16, FRAC=8, random a/b against reference model ((a<<8)/b, saturation rule) -> all results, latency 25 edges, and ovf/dbz flags match.
